ram_copy_ctrl: RTL and testbench

Block-transfer controller for the 128 x 8 true dual-port RAM. On a start pulse it copies a run of words from a source region to a destination region, or fills the destination region with a constant. It always reads through port 1 and writes through port 2. It sits between the host/control FSM and the RAM, owning both RAM ports while busy.

---
 rtl/ram_copy_ctrl.sv | 139 +++++++++++++
 tb/tb_ram_copy_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram_copy_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : ram_copy_ctrl
//  Purpose  : Block-transfer controller for a 2^AW x DW true dual-port RAM.
//             On start it copies len words from src to dst, or fills dst
//             with a constant. It reads through port 1 and writes through
//             port 2, one word per cycle, and allows for a RAM read latency
//             of one clock.
//  Ports    : clk, rst          - clock, synchronous active-high reset
//             start, mode       - request pulse; 0 = copy, 1 = fill
//             src, dst, len     - first source/dest address, word count
//                                 (0..2^AW, larger values are clamped)
//             fill_val          - fill constant
//             busy, done        - transfer in progress / completion pulse
//             a1, we1, d1, q1   - RAM port 1 (read only; we1 tied low)
//             a2, we2, d2       - RAM port 2 (write port)
//  Revision : 1.0 - initial release
// ============================================================================
module ram_copy_ctrl #(
  parameter int DW = 8,
  parameter int AW = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          mode,
  input  logic [AW-1:0] src,
  input  logic [AW-1:0] dst,
  input  logic [AW:0]   len,
  input  logic [DW-1:0] fill_val,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] a1,
  output logic          we1,
  output logic [DW-1:0] d1,
  input  logic [DW-1:0] q1,
  output logic [AW-1:0] a2,
  output logic          we2,
  output logic [DW-1:0] d2
);

  localparam logic [AW:0]   MAX_LEN = {1'b1, {AW{1'b0}}};
  localparam logic [AW-1:0] ONE_A   = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   ONE_N   = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t        state;
  logic          mode_q;
  logic [DW-1:0] fill_q;
  logic [AW-1:0] dst_q;
  logic [AW:0]   n_q;      // clamped word count
  logic [AW:0]   wr_idx;   // words whose write has been issued
  logic          we2_q;
  logic [AW:0]   len_c;

  assign len_c = (len > MAX_LEN) ? MAX_LEN : len;

  // Port 1 is only ever used for reading.
  assign we1 = 1'b0;
  assign d1  = '0;

  // The write strobe is masked by rst so that the edge which resets the
  // controller cannot also commit a pending write into the RAM.
  assign we2 = we2_q & ~rst;

  // Read data arrives one edge after a1, which is exactly the cycle in which
  // the matching write is presented, so copy data passes straight through.
  assign d2 = we2_q ? (mode_q ? fill_q : q1) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      we2_q  <= 1'b0;
      a1     <= '0;
      a2     <= '0;
      mode_q <= 1'b0;
      fill_q <= '0;
      dst_q  <= '0;
      n_q    <= '0;
      wr_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          done  <= 1'b0;
          we2_q <= 1'b0;
          if (start) begin
            mode_q <= mode;
            fill_q <= fill_val;
            dst_q  <= dst;
            n_q    <= len_c;
            wr_idx <= '0;
            a1     <= src;
            busy   <= 1'b1;
            if (len_c == '0) begin
              done  <= 1'b1;
              state <= FINISH;
            end else begin
              state <= RUN;
            end
          end
        end

        RUN: begin
          // Reads run one word ahead of writes; the extra read issued in
          // the final RUN cycle is harmless.
          a1 <= a1 + ONE_A;
          if (wr_idx == n_q) begin
            we2_q <= 1'b0;
            done  <= 1'b1;
            state <= FINISH;
          end else begin
            we2_q  <= 1'b1;
            a2     <= dst_q + wr_idx[AW-1:0];
            wr_idx <= wr_idx + ONE_N;
          end
        end

        FINISH: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          a1    <= '0;
          a2    <= '0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ram_copy_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ram_copy_ctrl
//  Purpose  : Self-checking bench for ram_copy_ctrl. A behavioural read-first
//             dual-port RAM is attached; a reference memory image predicts
//             every write, which is queued at start and compared when the
//             controller strobes we2.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ram_copy_ctrl;

  localparam int DW = 8;
  localparam int AW = 7;

  logic          clk = 1'b0;
  logic          rst, start, mode;
  logic [AW-1:0] src, dst;
  logic [AW:0]   len;
  logic [DW-1:0] fill_val;
  logic          busy, done, we1, we2;
  logic [AW-1:0] a1, a2;
  logic [DW-1:0] d1, d2, q1;

  always #5 clk = ~clk;

  ram_copy_ctrl #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .src(src), .dst(dst), .len(len), .fill_val(fill_val),
    .busy(busy), .done(done),
    .a1(a1), .we1(we1), .d1(d1), .q1(q1),
    .a2(a2), .we2(we2), .d2(d2)
  );

  // Behavioural RAM: registered read, read-first, plus a backdoor for preload.
  logic [DW-1:0] mem     [0:127];
  logic [DW-1:0] ref_mem [0:127];
  logic          bd_we;
  logic [AW-1:0] bd_a;
  logic [DW-1:0] bd_d;

  always @(posedge clk) begin
    if (bd_we) mem[bd_a] <= bd_d;
    if (we1)   mem[a1]   <= d1;
    if (we2)   mem[a2]   <= d2;
    q1 <= mem[a1];
  end

  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
  wr_t exp_q[$];

  int n_err = 0, n_checks = 0;
  int busy_cnt = 0, done_cnt = 0, wr_cnt = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Scoreboard consumer: every write strobe must match the next prediction.
  always @(negedge clk) begin
    wr_t e;
    if (busy) busy_cnt++;
    if (done) done_cnt++;
    if (we2) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_write", {25'd0, a2}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", {25'd0, a2}, {25'd0, e.addr});
        check("wr_data", {24'd0, d2}, {24'd0, e.data});
      end
    end
  end

  // Predict a transfer of n words of which the first nw are actually written.
  // Word j sees writes of words 0..j-2 only (word j-1 lands on the same edge
  // that reads word j, and the RAM is read-first).
  task automatic model_xfer(input logic m, input int s, input int d, input int n,
                            input logic [DW-1:0] f, input int nw);
    logic [DW-1:0] wd [128];
    wr_t e;
    for (int j = 0; j < n; j++) begin
      if (j >= 2 && (j - 2) < nw) ref_mem[(d + j - 2) % 128] = wd[j-2];
      wd[j] = m ? f : ref_mem[(s + j) % 128];
    end
    for (int j = 0; j < nw; j++) begin
      ref_mem[(d + j) % 128] = wd[j];
      e.addr = AW'((d + j) % 128);
      e.data = wd[j];
      exp_q.push_back(e);
    end
  endtask

  function automatic int mem_diffs();
    int k = 0;
    for (int i = 0; i < 128; i++) if (mem[i] !== ref_mem[i]) k++;
    return k;
  endfunction

  task automatic poke(input int a, input logic [DW-1:0] v);
    @(posedge clk); #1;
    bd_we = 1'b1; bd_a = AW'(a); bd_d = v;
    ref_mem[a] = v;
    @(posedge clk); #1;
    bd_we = 1'b0;
  endtask

  task automatic do_xfer(input logic m, input int s, input int d, input int l,
                         input logic [DW-1:0] f, input bit inj);
    int  n        = (l > 128) ? 128 : l;
    int  exp_busy = (n == 0) ? 1 : n + 2;
    int  done_at  = 0;
    bit  ended    = 0;
    model_xfer(m, s, d, n, f, n);
    busy_cnt = 0; done_cnt = 0; wr_cnt = 0;
    @(posedge clk); #1;
    start = 1'b1; mode = m; src = AW'(s); dst = AW'(d); len = (AW+1)'(l); fill_val = f;
    @(posedge clk); #1;
    // Scramble inputs after the start edge: parameters must stay latched.
    start = 1'b0; mode = ~m; src = 7'h55; dst = 7'h2A; len = 8'd3; fill_val = ~f;
    for (int c = 1; c <= n + 10; c++) begin
      @(negedge clk);
      if (inj && c == 2) begin
        start = 1'b1; mode = 1'b0; src = 7'd0; dst = 7'd100; len = 8'd2;
      end
      if (inj && c == 3) start = 1'b0;
      if (done && done_at == 0) done_at = c;
      if (!busy) begin ended = 1; break; end
    end
    #1;
    check("xfer_ends", {31'd0, ended}, 32'd1);
    check("busy_cycles", busy_cnt, exp_busy);
    check("done_cycle", done_at, exp_busy);
    check("done_count", done_cnt, 1);
    check("write_count", wr_cnt, n);
    check("queue_left", exp_q.size(), 0);
    check("mem_image", mem_diffs(), 0);
    exp_q.delete();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 1'b0; src = '0; dst = '0; len = '0;
    fill_val = '0; bd_we = 1'b0; bd_a = '0; bd_d = '0;
    repeat (3) @(posedge clk);
    #1;
    // rst and start on the same edge: rst wins.
    start = 1'b1; len = 8'd5;
    @(posedge clk); #1;
    start = 1'b0; rst = 1'b0;
    @(negedge clk);
    check("rst_beats_start", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_we2", {31'd0, we2}, 32'd0);
    check("rst_a1", {25'd0, a1}, 32'd0);
    check("rst_a2", {25'd0, a2}, 32'd0);
    check("rst_d2", {24'd0, d2}, 32'd0);
    check("rst_we1", {31'd0, we1}, 32'd0);
    check("rst_d1", {24'd0, d1}, 32'd0);

    for (int i = 0; i < 128; i++) poke(i, DW'((i * 37 + 5) & 255));
    for (int i = 0; i < 4; i++) poke(10 + i, DW'(8'hA0 + i));
    for (int i = 0; i < 4; i++) poke(20 + i, DW'(i + 1));

    // Copy basic
    do_xfer(1'b0, 10, 40, 4, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check("copy_dst", {24'd0, mem[40+i]}, 32'hA0 + i);
      check("copy_src_kept", {24'd0, mem[10+i]}, 32'hA0 + i);
    end

    // Fill with address wrap
    do_xfer(1'b1, 0, 126, 4, 8'h5A, 1'b0);
    check("fill_126", {24'd0, mem[126]}, 32'h5A);
    check("fill_127", {24'd0, mem[127]}, 32'h5A);
    check("fill_0", {24'd0, mem[0]}, 32'h5A);
    check("fill_1", {24'd0, mem[1]}, 32'h5A);
    check("fill_2_kept", {24'd0, mem[2]}, 32'd2 * 37 + 5);

    // Zero-length transfer
    do_xfer(1'b0, 5, 60, 0, 8'h00, 1'b0);

    // Overlap dst = src + 1
    do_xfer(1'b0, 20, 21, 3, 8'h00, 1'b0);
    check("ovl_21", {24'd0, mem[21]}, 32'd1);
    check("ovl_22", {24'd0, mem[22]}, 32'd2);
    check("ovl_23", {24'd0, mem[23]}, 32'd3);

    // Second start while busy is ignored
    do_xfer(1'b0, 50, 80, 6, 8'h00, 1'b1);

    // Reset mid-transfer: rst sampled on the edge after word 3 lands
    model_xfer(1'b0, 0, 64, 8, 8'h00, 4);
    busy_cnt = 0; done_cnt = 0; wr_cnt = 0;
    @(posedge clk); #1;
    start = 1'b1; mode = 1'b0; src = 7'd0; dst = 7'd64; len = 8'd8;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rstmid_busy", {31'd0, busy}, 32'd0);
    check("rstmid_we2", {31'd0, we2}, 32'd0);
    repeat (4) @(negedge clk);
    check("rstmid_no_done", done_cnt, 0);
    check("rstmid_writes", wr_cnt, 4);
    check("rstmid_queue", exp_q.size(), 0);
    check("rstmid_mem68_kept", {24'd0, mem[68]}, {24'd0, ref_mem[68]});
    check("rstmid_mem_image", mem_diffs(), 0);
    exp_q.delete();

    // Normal operation after the reset
    do_xfer(1'b0, 10, 90, 4, 8'h00, 1'b0);

    // Oversized length is clamped to the full array
    do_xfer(1'b1, 0, 0, 200, 8'hC3, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
